arf_state_sequencer: RTL
========================

Name: arf_state_sequencer

Overview:
Sequential wrapper stage around the combinational ARF datapath. Accepts one input sample pair per handshake, drives the datapath's eight recursive-state operands and two fresh inputs from registers, waits a parameterised datapath latency, then captures the two filter outputs. The captured outputs are presented on a valid/ready output port and also shifted back into the state tap lines for the next sample.

Parameters:
WIDTH, 16, bit width of every sample, state tap and datapath operand/result
DP_LATENCY, 0, clock cycles from stable operands to valid datapath results (0 = purely combinational datapath)
CNT_W, 16, width of the processed-sample counter

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous zeroing of state taps; sampled only in IDLE
s_valid  in  1  input sample pair valid
s_ready  out  1  sequencer can accept a sample
s_x0  in  WIDTH  fresh input 0, feeds datapath in_13_1
s_x1  in  WIDTH  fresh input 1, feeds datapath in_14_1
dp_state  out  8*WIDTH  taps {a0,a1,a2,a3,b0,b1,b2,b3}, slice i (LSB first) drives in_(i+1)_0
dp_x0  out  WIDTH  registered s_x0
dp_x1  out  WIDTH  registered s_x1
dp_y0  in  WIDTH  datapath out_27
dp_y1  in  WIDTH  datapath out_28
m_valid  out  1  captured result valid
m_ready  in  1  downstream accepts result
m_y0  out  WIDTH  captured dp_y0
m_y1  out  WIDTH  captured dp_y1
busy  out  1  high in any state other than IDLE
sample_cnt  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Both are fixed.
- Reset, or rst asserted in any state including mid-WAIT or mid-HOLD: next cycle state=IDLE, all taps 0, dp_x0/dp_x1=0, m_y0/m_y1=0, m_valid=0, sample_cnt=0, wait counter 0. An in-flight sample is dropped.
- FSM states: IDLE, WAIT, HOLD.
- IDLE: s_ready = !clear.
  - clear=1: all eight taps zeroed; no sample accepted, even if s_valid=1.
  - s_valid & s_ready: latch s_x0/s_x1 into dp_x0/dp_x1; load wait counter with DP_LATENCY; go to WAIT.
- WAIT: s_ready=0; clear ignored.
  - Counter != 0: decrement.
  - Counter == 0: capture dp_y0→m_y0 and dp_y1→m_y1; shift a3←a2←a1←a0←dp_y0 and b3←b2←b1←b0←dp_y1; m_valid←1; go to HOLD.
- Timing: accept on edge E. Operands are stable from E+1. Capture and m_valid rise occur on edge E+1+DP_LATENCY.
- HOLD: m_valid=1. m_y0/m_y1, taps and dp_x0/dp_x1 are stable. On m_ready: m_valid←0, sample_cnt←sample_cnt+1 (wrapping), go to IDLE. No stall limit.
- Throughput: one sample per DP_LATENCY+3 cycles minimum. No overlap is allowed because of the recursive dependency.
- Arithmetic: the sequencer performs none. Values are registered bit-exact at WIDTH; datapath wrap/truncation is not altered.
- dp_* outputs are driven only from registers; no combinational path from s_* to dp_*.

Decomposition:
- Package arf_pkg:
  - WIDTH default
  - TAP_DEPTH=4
  - NUM_LINES=2
  - state enum {IDLE, WAIT, HOLD}
  - latency counter width derived from DP_LATENCY (minimum 1 bit)
- Sub-module arf_tap_line:
  - one TAP_DEPTH-deep shift line with sync rst, sync clear and shift-enable
  - exposes all taps flat
  - instantiated twice (lines a and b)

Test Plan:
- Reset: hold rst 2 cycles with s_valid=1 and m_ready=1 → s_ready=1, m_valid=0, dp_state=0, dp_x0=dp_x1=0, sample_cnt=0.
- Single sample, DP_LATENCY=2: accept x0=3, x1=5 at edge 10; bench drives y0=16'h0011, y1=16'h0022 → dp_x0=3 and dp_x1=5 from cycle 11, m_valid rises after edge 13, a0=16'h0011, b0=16'h0022, other taps 0.
- Tap shifting, DP_LATENCY=0: five samples with y0=1,2,3,4,5 and y1=y0+16'h100, m_ready=1 → after the 4th, a0..a3=4,3,2,1; after the 5th, a0..a3=5,4,3,2 and b0..b3=16'h105,16'h104,16'h103,16'h102; sample_cnt=5.
- Backpressure: m_ready=0 for 6 cycles in HOLD with s_valid=1 → m_y0/m_y1 and taps unchanged, s_ready=0 throughout; handshake on cycle 7 → IDLE, sample_cnt increments by 1.
- Clear: taps nonzero, clear=1 and s_valid=1 in IDLE → taps all 0 next cycle, s_ready=0 that cycle, sample not accepted. clear asserted during WAIT → ignored, normal capture.
- Reset mid-operation: rst in the 2nd WAIT cycle (DP_LATENCY=3) → next cycle IDLE, taps 0, m_valid never rises, sample_cnt=0.

Source files
------------

// File: rtl/arf_pkg.sv
// arf_pkg: shared types and sizing for the ARF state sequencer
package arf_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int TAP_DEPTH = 4;
    localparam int NUM_LINES = 2;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    function automatic int lat_w(int lat);
        return lat < 2 ? 1 : $clog2(lat + 1);
    endfunction
endpackage

// File: rtl/arf_tap_line.sv
// arf_tap_line: TAP_DEPTH-deep recursive state shift line, tap 0 in the LSB slice
module arf_tap_line
    import arf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       shift,
    input  logic [WIDTH-1:0]           din,
    output logic [TAP_DEPTH*WIDTH-1:0] taps
);
    always_ff @(posedge clk)
        if (rst || clear) taps <= '0;
        else if (shift) taps <= {taps[(TAP_DEPTH-1)*WIDTH-1:0], din};
endmodule

// File: rtl/arf_state_sequencer.sv
// arf_state_sequencer: registers operands for the ARF datapath, waits its latency, captures and recirculates results
module arf_state_sequencer
    import arf_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DP_LATENCY = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_x0,
    input  logic [WIDTH-1:0]       s_x1,
    output logic [8*WIDTH-1:0]     dp_state,
    output logic [WIDTH-1:0]       dp_x0,
    output logic [WIDTH-1:0]       dp_x1,
    input  logic [WIDTH-1:0]       dp_y0,
    input  logic [WIDTH-1:0]       dp_y1,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_y0,
    output logic [WIDTH-1:0]       m_y1,
    output logic                   busy,
    output logic [CNT_W-1:0]       sample_cnt
);
    localparam int LAT_W = lat_w(DP_LATENCY);
    state_t state, state_nx;
    logic [LAT_W-1:0] cnt;
    logic accept, capture, done, tap_clear;
    logic [TAP_DEPTH*WIDTH-1:0] a_taps, b_taps;
    always_comb begin
        state_nx  = state;
        s_ready   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        tap_clear = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready   = !clear;
                tap_clear = clear;
                accept    = s_valid && !clear;
                state_nx  = accept ? WAIT : IDLE;
            end
            WAIT: begin
                capture  = cnt == '0;
                state_nx = capture ? HOLD : WAIT;
            end
            HOLD: begin
                done     = m_ready;
                state_nx = m_ready ? IDLE : HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dp_x0      <= '0;
            dp_x1      <= '0;
            m_y0       <= '0;
            m_y1       <= '0;
            sample_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dp_x0 <= s_x0;
                dp_x1 <= s_x1;
                cnt   <= LAT_W'(DP_LATENCY);
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (capture) begin
                m_y0 <= dp_y0;
                m_y1 <= dp_y1;
            end
            if (done) sample_cnt <= sample_cnt + 1'b1;
        end
    assign m_valid  = state == HOLD;
    assign busy     = state != IDLE;
    assign dp_state = {b_taps, a_taps};
    arf_tap_line #(.WIDTH(WIDTH)) u_line_a (
        .clk(clk), .rst(rst), .clear(tap_clear), .shift(capture), .din(dp_y0), .taps(a_taps)
    );
    arf_tap_line #(.WIDTH(WIDTH)) u_line_b (
        .clk(clk), .rst(rst), .clear(tap_clear), .shift(capture), .din(dp_y1), .taps(b_taps)
    );
endmodule
